// File: rtl/thr2pry_pkg.sv
// Shared definitions for the thermometer-to-priority pipeline.
//   DIR_LSB / DIR_MSB : accepted values of the DIRECTION parameter
//   idx_width()       : index width for a vector of w bits (at least 1)
//   seg_decode()      : decodes one segment (up to SEG_MAX bits wide) into
//                       its one-hot edge, local index, any-bit and local
//                       monotonicity error. Stage 1 uses it per input
//                       segment; stage 2 reuses it on the vector of segment
//                       any-bits to pick the winning segment.
package thr2pry_pkg;

  localparam string DIR_LSB = "LSB";
  localparam string DIR_MSB = "MSB";
  localparam int    SEG_MAX = 32;

  typedef struct packed {
    logic [SEG_MAX-1:0] edge_oh;
    logic [4:0]         idx;
    logic               any;
    logic               err;
  } seg_dec_t;

  function automatic int idx_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Only bits [w-1:0] of v are considered; callers zero-extend.
  // msb=0: edge is the lowest set bit and a 1 followed by a 0 above it is
  // an error. msb=1: edge is the highest set bit, mirrored error rule.
  function automatic seg_dec_t seg_decode(input logic [SEG_MAX-1:0] v,
                                          input int w, input bit msb);
    seg_dec_t d;
    bit       found;
    d     = '0;
    found = 1'b0;
    for (int k = 0; k < SEG_MAX; k++) begin
      if (k < w) begin
        int i;
        i = msb ? (w - 1 - k) : k;
        if (!found && v[i[4:0]]) begin
          found             = 1'b1;
          d.edge_oh[i[4:0]] = 1'b1;
          d.idx             = 5'(i);
        end
      end
      if (k < w - 1) begin
        int j;
        j = k + 1;
        if (msb ? (v[j[4:0]] && !v[k[4:0]]) : (v[k[4:0]] && !v[j[4:0]]))
          d.err = 1'b1;
      end
    end
    d.any = |v;
    return d;
  endfunction

endpackage

// File: rtl/thr2pry_seg.sv
// Combinational decoder for one SPLIT-wide segment of the thermometer word.
// Optional feature macro: THR2PRY_PIPE_ERR_EN (adds err/lo/hi outputs).
// Ports:
//   seg     in  W    segment bits
//   edge_oh out W    one-hot segment-local edge
//   idx     out LIW  segment-local index of the edge
//   any     out 1    any bit set in the segment
//   err     out 1    segment-local monotonicity error   (macro only)
//   lo, hi  out 1    lowest / highest segment bit       (macro only)
module thr2pry_seg
  import thr2pry_pkg::*;
#(
  parameter int  W   = 3,
  parameter bit  MSB = 1'b0,
  localparam int LIW = idx_width(W)
) (
  input  logic [W-1:0]   seg,
  output logic [W-1:0]   edge_oh,
  output logic [LIW-1:0] idx,
  output logic           any
`ifdef THR2PRY_PIPE_ERR_EN
  ,
  output logic           err,
  output logic           lo,
  output logic           hi
`endif
);

  always_comb begin
    seg_dec_t d;
    d       = seg_decode(SEG_MAX'(seg), W, MSB);
    edge_oh = d.edge_oh[W-1:0];
    idx     = LIW'(d.idx);
    any     = d.any;
`ifdef THR2PRY_PIPE_ERR_EN
    err     = d.err;
`endif
  end

`ifdef THR2PRY_PIPE_ERR_EN
  // Boundary bits feed the inter-segment check in stage 2.
  assign lo = seg[0];
  assign hi = seg[W-1];
`endif

endmodule

// File: rtl/thr2pry_pipe.sv
// Two-stage pipelined thermometer-to-priority decoder with valid/ready
// backpressure. Stage 1 decodes each SPLIT-bit segment; stage 2 picks the
// first non-empty segment from the DIRECTION side and assembles the result.
// Optional feature macro: THR2PRY_PIPE_ERR_EN (monotonicity check; when
// undefined m_err is tied 0 and no check logic or error registers exist).
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   s_vld/s_rdy    input handshake, s_thr thermometer word (WIDTH)
//   m_vld/m_rdy    output handshake
//   m_pry (WIDTH)  one-hot priority edge, m_idx its binary index
//   m_any          any bit set in the word, m_err non-thermometer input
module thr2pry_pipe
  import thr2pry_pkg::*;
#(
  parameter int    WIDTH     = 9,
  parameter int    SPLIT     = 3,
  parameter string DIRECTION = DIR_LSB,
  localparam int   IDX_W     = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_thr,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [WIDTH-1:0] m_pry,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_any,
  output logic             m_err
);

  localparam int NSEG = WIDTH / SPLIT;
  localparam int LIW  = idx_width(SPLIT);
  localparam bit MSB  = (DIRECTION == DIR_MSB);

  if (WIDTH < 2 || SPLIT < 1 || (WIDTH % SPLIT) != 0 ||
      SPLIT > SEG_MAX || NSEG > SEG_MAX) begin : g_bad_split
    $fatal(1, "thr2pry_pipe: WIDTH must be >= 2 and a multiple of SPLIT");
  end
  if (DIRECTION != DIR_LSB && DIRECTION != DIR_MSB) begin : g_bad_dir
    $fatal(1, "thr2pry_pipe: DIRECTION must be \"LSB\" or \"MSB\"");
  end

  logic vld_p1, vld_p2, rdy_p1, rdy_p2;

  assign rdy_p2 = !vld_p2 || m_rdy;
  assign rdy_p1 = !vld_p1 || rdy_p2;
  assign s_rdy  = rdy_p1;

  logic [SPLIT-1:0] edge_c [NSEG];
  logic [LIW-1:0]   lidx_c [NSEG];
  logic [NSEG-1:0]  any_c;
`ifdef THR2PRY_PIPE_ERR_EN
  logic [NSEG-1:0]  err_c, lo_c, hi_c;
`endif

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    thr2pry_seg #(.W(SPLIT), .MSB(MSB)) u_seg (
      .seg     (s_thr[g*SPLIT +: SPLIT]),
      .edge_oh (edge_c[g]),
      .idx     (lidx_c[g]),
      .any     (any_c[g])
`ifdef THR2PRY_PIPE_ERR_EN
      ,
      .err     (err_c[g]),
      .lo      (lo_c[g]),
      .hi      (hi_c[g])
`endif
    );
  end

  // ---- stage 1: per-segment partial decode ----
  logic [SPLIT-1:0] edge_p1 [NSEG];
  logic [LIW-1:0]   lidx_p1 [NSEG];
  logic [NSEG-1:0]  any_p1;
`ifdef THR2PRY_PIPE_ERR_EN
  logic [NSEG-1:0]  err_p1, lo_p1, hi_p1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      any_p1 <= '0;
      for (int k = 0; k < NSEG; k++) begin
        edge_p1[k] <= '0;
        lidx_p1[k] <= '0;
      end
`ifdef THR2PRY_PIPE_ERR_EN
      err_p1 <= '0;
      lo_p1  <= '0;
      hi_p1  <= '0;
`endif
    end else if (rdy_p1) begin
      vld_p1 <= s_vld;
      if (s_vld) begin
        any_p1 <= any_c;
        for (int k = 0; k < NSEG; k++) begin
          edge_p1[k] <= edge_c[k];
          lidx_p1[k] <= lidx_c[k];
        end
`ifdef THR2PRY_PIPE_ERR_EN
        err_p1 <= err_c;
        lo_p1  <= lo_c;
        hi_p1  <= hi_c;
`endif
      end
    end
  end

  // ---- stage 2: segment select and result assembly ----
  logic [WIDTH-1:0] pry_c;
  logic [IDX_W-1:0] idx_c;
  logic             any_s;
`ifdef THR2PRY_PIPE_ERR_EN
  logic             err_s;
`endif

  always_comb begin
    seg_dec_t sel;
    // The segment any-bits behave like a coarse word: its edge is the winner.
    sel   = seg_decode(SEG_MAX'(any_p1), NSEG, MSB);
    pry_c = '0;
    idx_c = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (sel.edge_oh[k]) begin
        pry_c[k*SPLIT +: SPLIT] = edge_p1[k];
        idx_c = IDX_W'(k * SPLIT + int'(lidx_p1[k]));
      end
    end
    any_s = sel.any;
`ifdef THR2PRY_PIPE_ERR_EN
    err_s = |err_p1;
    for (int k = 0; k < NSEG - 1; k++) begin
      if (MSB ? (lo_p1[k+1] && !hi_p1[k]) : (hi_p1[k] && !lo_p1[k+1]))
        err_s = 1'b1;
    end
`endif
  end

  logic [WIDTH-1:0] pry_p2;
  logic [IDX_W-1:0] idx_p2;
  logic             any_p2;
`ifdef THR2PRY_PIPE_ERR_EN
  logic             err_p2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      pry_p2 <= '0;
      idx_p2 <= '0;
      any_p2 <= 1'b0;
`ifdef THR2PRY_PIPE_ERR_EN
      err_p2 <= 1'b0;
`endif
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pry_p2 <= pry_c;
        idx_p2 <= idx_c;
        any_p2 <= any_s;
`ifdef THR2PRY_PIPE_ERR_EN
        err_p2 <= err_s;
`endif
      end
    end
  end

  // ---- output ----
  assign m_vld = vld_p2;
  assign m_pry = pry_p2;
  assign m_idx = idx_p2;
  assign m_any = any_p2;
`ifdef THR2PRY_PIPE_ERR_EN
  assign m_err = err_p2;
`else
  assign m_err = 1'b0;
`endif

endmodule
